// File: rtl/uart_core.sv
// uart_core: full-duplex UART transceiver with valid/ready byte handshakes.
//
// Frame: start bit (0), DATA_WIDTH data bits LSB first, optional even
// parity bit, one stop bit (1). Bit time DIV = CLK_FREQ/BAUD_RATE clocks.
//
// Optional feature macro: UART_PARITY_EN
//   defined   -> one even-parity bit after the data bits (TX inserts, RX checks)
//   undefined -> plain 8N1, no parity logic
//
// Ports:
//   clk           sole clock, rising edge
//   rstn          asynchronous active-low reset
//   rx_sig        serial line in (idle high)
//   rx_data       received character, stable while rx_valid is high
//   rx_valid      rx_data holds an unconsumed character
//   rx_ready      consumer accepts rx_data
//   rx_frame_err  one-cycle pulse: bad stop bit (or parity mismatch)
//   rx_overrun    one-cycle pulse: character completed over an unconsumed one
//   tx_sig        serial line out (idle high)
//   tx_data       character to send
//   tx_valid      tx_data is offered
//   tx_ready      transmitter can accept a character
//
// TX and RX state machines (same encoding for both):
//   state    | meaning
//   S_IDLE   | line idle, waiting for a handshake / falling edge
//   S_START  | start bit (TX: driving 0, RX: waiting for mid-bit sample)
//   S_DATA   | data bits, LSB first
//   S_PARITY | even parity bit (only reachable with UART_PARITY_EN)
//   S_STOP   | stop bit
module uart_core #(
  parameter int DATA_WIDTH = 8,
  parameter int BAUD_RATE  = 115200,
  parameter int CLK_FREQ   = 100_000_000
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  rx_sig,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  output logic                  rx_frame_err,
  output logic                  rx_overrun,
  output logic                  tx_sig,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready
);

  localparam int DIV   = CLK_FREQ / BAUD_RATE;
  localparam int HALF  = DIV / 2;
  localparam int CNT_W = $clog2(DIV + 1);
  localparam int BIT_W = $clog2(DATA_WIDTH + 1);

  localparam logic [CNT_W-1:0] DIV_M1   = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(HALF - 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  // ---------------------------------------------------------------- TX
  state_t                tx_state, tx_state_nxt;
  logic [CNT_W-1:0]      tx_cnt;
  logic [BIT_W-1:0]      tx_bit;
  logic [DATA_WIDTH-1:0] tx_shift;
  logic [DATA_WIDTH-1:0] tx_shift_nxt;
  logic                  tx_tick;
  logic                  tx_sig_nxt;
`ifdef UART_PARITY_EN
  logic                  tx_par;
`endif

  assign tx_tick      = (tx_cnt == '0);
  assign tx_shift_nxt = tx_shift >> 1;

  // tx_ready is also raised in the last cycle of the stop bit so a waiting
  // character starts its start bit with no idle gap.
  always_comb begin
    tx_state_nxt = tx_state;
    tx_sig_nxt   = tx_sig;
    tx_ready     = 1'b0;
    case (tx_state)
      S_IDLE: begin
        tx_ready   = 1'b1;
        tx_sig_nxt = 1'b1;
        if (tx_valid) begin
          tx_state_nxt = S_START;
          tx_sig_nxt   = 1'b0;
        end
      end
      S_START: begin
        if (tx_tick) begin
          tx_state_nxt = S_DATA;
          tx_sig_nxt   = tx_shift[0];
        end
      end
      S_DATA: begin
        if (tx_tick) begin
          if (tx_bit == LAST_BIT) begin
`ifdef UART_PARITY_EN
            tx_state_nxt = S_PARITY;
            tx_sig_nxt   = tx_par;
`else
            tx_state_nxt = S_STOP;
            tx_sig_nxt   = 1'b1;
`endif
          end else begin
            tx_sig_nxt = tx_shift_nxt[0];
          end
        end
      end
`ifdef UART_PARITY_EN
      S_PARITY: begin
        if (tx_tick) begin
          tx_state_nxt = S_STOP;
          tx_sig_nxt   = 1'b1;
        end
      end
`endif
      S_STOP: begin
        if (tx_tick) begin
          tx_ready = 1'b1;
          if (tx_valid) begin
            tx_state_nxt = S_START;
            tx_sig_nxt   = 1'b0;
          end else begin
            tx_state_nxt = S_IDLE;
          end
        end
      end
      default: begin
        tx_state_nxt = S_IDLE;
        tx_sig_nxt   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tx_state <= S_IDLE;
      tx_sig   <= 1'b1;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
`ifdef UART_PARITY_EN
      tx_par   <= 1'b0;
`endif
    end else begin
      tx_state <= tx_state_nxt;
      tx_sig   <= tx_sig_nxt;
      if (tx_valid && tx_ready) begin
        tx_shift <= tx_data;
        tx_cnt   <= DIV_M1;
        tx_bit   <= '0;
`ifdef UART_PARITY_EN
        tx_par   <= ^tx_data;
`endif
      end else if (tx_state != S_IDLE) begin
        if (tx_tick) begin
          tx_cnt <= DIV_M1;
          if (tx_state == S_DATA) begin
            tx_shift <= tx_shift_nxt;
            tx_bit   <= tx_bit + 1'b1;
          end
        end else begin
          tx_cnt <= tx_cnt - 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------- RX
  state_t                rx_state, rx_state_nxt;
  logic                  rx_s1, rx_s2, rx_s3;
  logic                  rx_fall;
  logic [CNT_W-1:0]      rx_cnt;
  logic [BIT_W-1:0]      rx_bit;
  logic [DATA_WIDTH-1:0] rx_shift;
  logic                  rx_tick;
  logic                  rx_done;
  logic                  rx_bad;
`ifdef UART_PARITY_EN
  logic                  rx_par_err;
`endif

  // rx_s3 is only an edge-detect delay of the synchronized line; a low line
  // left over from a bad stop bit cannot re-arm until it has gone high again.
  assign rx_fall = rx_s3 & ~rx_s2;
  assign rx_tick = (rx_cnt == '0);

  always_comb begin
    rx_state_nxt = rx_state;
    rx_done      = 1'b0;
    rx_bad       = 1'b0;
    case (rx_state)
      S_IDLE: begin
        if (rx_fall) rx_state_nxt = S_START;
      end
      S_START: begin
        if (rx_tick) rx_state_nxt = rx_s2 ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        if (rx_tick && (rx_bit == LAST_BIT)) begin
`ifdef UART_PARITY_EN
          rx_state_nxt = S_PARITY;
`else
          rx_state_nxt = S_STOP;
`endif
        end
      end
`ifdef UART_PARITY_EN
      S_PARITY: begin
        if (rx_tick) rx_state_nxt = S_STOP;
      end
`endif
      S_STOP: begin
        if (rx_tick) begin
          rx_state_nxt = S_IDLE;
`ifdef UART_PARITY_EN
          if (rx_s2 && !rx_par_err) rx_done = 1'b1;
          else                      rx_bad  = 1'b1;
`else
          if (rx_s2) rx_done = 1'b1;
          else       rx_bad  = 1'b1;
`endif
        end
      end
      default: rx_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_s1        <= 1'b1;
      rx_s2        <= 1'b1;
      rx_s3        <= 1'b1;
      rx_state     <= S_IDLE;
      rx_cnt       <= '0;
      rx_bit       <= '0;
      rx_shift     <= '0;
`ifdef UART_PARITY_EN
      rx_par_err   <= 1'b0;
`endif
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
      rx_overrun   <= 1'b0;
    end else begin
      rx_s1    <= rx_sig;
      rx_s2    <= rx_s1;
      rx_s3    <= rx_s2;
      rx_state <= rx_state_nxt;

      // First sample lands HALF cycles after the edge, then every DIV.
      if (rx_state == S_IDLE) begin
        rx_cnt <= HALF_M1;
        rx_bit <= '0;
      end else if (rx_tick) begin
        rx_cnt <= DIV_M1;
        if (rx_state == S_DATA) begin
          rx_shift <= {rx_s2, rx_shift[DATA_WIDTH-1:1]};
          rx_bit   <= rx_bit + 1'b1;
        end
`ifdef UART_PARITY_EN
        if (rx_state == S_PARITY) rx_par_err <= rx_s2 ^ (^rx_shift);
`endif
      end else begin
        rx_cnt <= rx_cnt - 1'b1;
      end

      rx_frame_err <= rx_bad;
      // A consume in the same cycle as a completion is not an overrun.
      rx_overrun   <= rx_done & rx_valid & ~rx_ready;
      if (rx_done) begin
        rx_data  <= rx_shift;
        rx_valid <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_core.sv
// tb_uart_core: self-checking bench for uart_core at default parameters
// (8N1, DIV=868). Received characters are checked by a scoreboard monitor;
// TX line timing is checked against frame bits built from the data byte.
module tb_uart_core;

  localparam int CLK_FREQ = 100_000_000;
  localparam int BAUD     = 115200;
  localparam int DIV      = CLK_FREQ / BAUD;
  localparam int HALF     = DIV / 2;

  logic       clk = 1'b0;
  logic       rstn;
  logic       rx_sig;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       rx_frame_err;
  logic       rx_overrun;
  logic       tx_sig;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  logic       loop;
  logic       rx_drv;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int fe_cnt   = 0;
  int ov_cnt   = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  assign rx_sig = loop ? tx_sig : rx_drv;

  uart_core #(
    .DATA_WIDTH(8),
    .BAUD_RATE (BAUD),
    .CLK_FREQ  (CLK_FREQ)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .rx_sig      (rx_sig),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .rx_frame_err(rx_frame_err),
    .rx_overrun  (rx_overrun),
    .tx_sig      (tx_sig),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every consumed character must be the next expected one.
  always @(negedge clk) begin
    if (rstn) begin
      if (rx_frame_err) fe_cnt++;
      if (rx_overrun)   ov_cnt++;
      if (rx_valid && rx_ready) begin
        if (exp_q.size() == 0) begin
          check("rx_unexpected_char", {24'd0, rx_data}, 32'hFFFF_FFFF);
        end else begin
          check("rx_char", {24'd0, rx_data}, {24'd0, exp_q.pop_front()});
        end
      end
    end
  end

  initial begin
    repeat (150000) @(posedge clk);
    $display("FAIL watchdog cycles=%0d limit=150000", cyc);
    $fatal(1, "watchdog");
  end

  // Offer d and wait for the handshake edge; returns at +1 after that edge
  // with tx_valid still high and the handshake cycle number in t_hs.
  task automatic tx_send(input logic [7:0] d, output int t_hs);
    int n;
    tx_data  = d;
    tx_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!tx_ready && n < 12 * DIV) begin
      @(negedge clk);
      n++;
    end
    check("tx_handshake_timeout", {31'd0, tx_ready}, 32'd1);
    check("tx_line_high_before_start", {31'd0, tx_sig}, 32'd1);
    @(posedge clk);
    #1;
    t_hs = cyc;
    if (loop) exp_q.push_back(d);
    check("tx_start_low", {31'd0, tx_sig}, 32'd0);
  endtask

  task automatic rx_frame(input logic [7:0] d, input logic stop);
    logic [9:0] f;
    f = {stop, d, 1'b0};
    for (int b = 0; b < 10; b++) begin
      rx_drv = f[b];
      repeat (DIV) @(posedge clk);
      #1;
    end
    rx_drv = 1'b1;
  endtask

  task automatic pulse_ready();
    rx_ready = 1'b1;
    @(posedge clk);
    #1;
    rx_ready = 1'b0;
  endtask

  initial begin
    int t0, t1, t2, t3;
    int fe0, ov0, n;
    logic [9:0] frame;
    logic [7:0] rnd;

    rstn     = 1'b0;
    loop     = 1'b0;
    rx_drv   = 1'b1;
    rx_ready = 1'b0;
    tx_valid = 1'b0;
    tx_data  = 8'h00;

    repeat (5) @(posedge clk);
    #1;
    check("rst_tx_sig", {31'd0, tx_sig}, 32'd1);
    check("rst_tx_ready", {31'd0, tx_ready}, 32'd1);
    check("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
    check("rst_rx_data", {24'd0, rx_data}, 32'd0);
    check("rst_rx_frame_err", {31'd0, rx_frame_err}, 32'd0);
    check("rst_rx_overrun", {31'd0, rx_overrun}, 32'd0);
    rstn = 1'b1;
    repeat ($urandom_range(3, 20)) @(posedge clk);
    #1;

    // TX 0x30 bit-cell pattern, looped back into RX.
    loop     = 1'b1;
    rx_ready = 1'b1;
    tx_send(8'h30, t0);
    tx_valid = 1'b0;
    tx_data  = 8'($urandom);
    frame    = {1'b1, 8'h30, 1'b0};
    repeat (HALF) @(posedge clk);
    #1;
    for (int b = 0; b < 10; b++) begin
      check($sformatf("tx_0x30_bit%0d", b), {31'd0, tx_sig}, {31'd0, frame[b]});
      if (b < 9) begin
        repeat (DIV) @(posedge clk);
        #1;
      end
    end
    repeat (DIV - HALF - 2) @(posedge clk);
    #1;
    check("tx_ready_low_before_frame_end", {31'd0, tx_ready}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("tx_ready_high_after_frame", {31'd0, tx_ready}, 32'd1);
    check("tx_idle_high_after_frame", {31'd0, tx_sig}, 32'd1);
    repeat ($urandom_range(5, 50)) @(posedge clk);
    #1;

    // Back-to-back loopback 0x00, 0xFF, random: no gap between frames.
    rnd = 8'($urandom);
    tx_send(8'h00, t1);
    tx_send(8'hFF, t2);
    tx_send(rnd, t3);
    tx_valid = 1'b0;
    tx_data  = 8'($urandom);
    check("b2b_gap_00_ff", t2 - t1, 10 * DIV);
    check("b2b_gap_ff_rnd", t3 - t2, 10 * DIV);
    n = 0;
    while ((!tx_ready || exp_q.size() != 0) && n < 12 * DIV) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("loopback_drained", exp_q.size(), 0);
    repeat (20) @(posedge clk);
    #1;
    loop     = 1'b0;
    rx_ready = 1'b0;

    // Reset in the middle of a TX start bit.
    tx_send(8'($urandom), t0);
    tx_valid = 1'b0;
    repeat (HALF) @(posedge clk);
    #1;
    check("midtx_line_low", {31'd0, tx_sig}, 32'd0);
    rstn = 1'b0;
    #1;
    check("midtx_reset_tx_sig", {31'd0, tx_sig}, 32'd1);
    check("midtx_reset_tx_ready", {31'd0, tx_ready}, 32'd1);
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b1;
    repeat ($urandom_range(20, 60)) @(posedge clk);
    #1;
    check("midtx_no_rx_output", {31'd0, rx_valid}, 32'd0);

    // RX 0xA5 held until consumed.
    exp_q.push_back(8'hA5);
    rx_frame(8'hA5, 1'b1);
    check("rx_a5_valid", {31'd0, rx_valid}, 32'd1);
    check("rx_a5_data", {24'd0, rx_data}, 32'hA5);
    repeat (100) @(posedge clk);
    #1;
    check("rx_a5_held_valid", {31'd0, rx_valid}, 32'd1);
    check("rx_a5_held_data", {24'd0, rx_data}, 32'hA5);
    pulse_ready();
    check("rx_a5_consumed", {31'd0, rx_valid}, 32'd0);
    check("rx_a5_scoreboard_empty", exp_q.size(), 0);

    // Overrun: 0x11 then 0x22 without consuming; 0x22 overwrites.
    ov0 = ov_cnt;
    fe0 = fe_cnt;
    exp_q.push_back(8'h22);
    rx_frame(8'h11, 1'b1);
    rx_frame(8'h22, 1'b1);
    check("ovr_pulse_count", ov_cnt - ov0, 1);
    check("ovr_valid", {31'd0, rx_valid}, 32'd1);
    check("ovr_data", {24'd0, rx_data}, 32'h22);
    pulse_ready();
    check("ovr_consumed", {31'd0, rx_valid}, 32'd0);
    check("ovr_no_frame_err", fe_cnt - fe0, 0);

    // Stop bit low: frame error, nothing delivered.
    repeat ($urandom_range(10, 40)) @(posedge clk);
    #1;
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    rx_frame(8'($urandom), 1'b0);
    repeat (10) @(posedge clk);
    #1;
    check("ferr_pulse_count", fe_cnt - fe0, 1);
    check("ferr_no_valid", {31'd0, rx_valid}, 32'd0);
    check("ferr_no_overrun", ov_cnt - ov0, 0);

    // 200-cycle low glitch: false start, no output of any kind.
    fe0 = fe_cnt;
    rx_drv = 1'b0;
    repeat (200) @(posedge clk);
    #1;
    rx_drv = 1'b1;
    repeat (10 * DIV) @(posedge clk);
    #1;
    check("glitch_no_valid", {31'd0, rx_valid}, 32'd0);
    check("glitch_no_frame_err", fe_cnt - fe0, 0);
    check("final_scoreboard_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
